trace_checker: RTL and testbench

Consumer end of the retirement probe stream. Takes the per-instruction `check_en`/`check_pc`/`check_data`/`check_addr` stream and compares it in order against an expected trace delivered over a valid/ready port, normally from a golden-trace ROM reader. It buffers retired entries in a small FIFO, counts matches and mismatches, captures the first failure, and reports pass, fail and done to the board-level harness.

---
 rtl/trace_checker.sv | 279 +++++++++++++++++++++++++++
 tb/tb_trace_checker.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_checker.sv
// -----------------------------------------------------------------------------
// trace_checker
//
// Consumer end of the retirement probe stream. Retired instructions
// (check_en / check_pc / check_data / check_addr) are buffered in a small
// retire FIFO. They are then compared in order against an expected trace that
// arrives over a valid/ready port. The block counts matches and mismatches,
// captures the first failure and reports pass / fail / done.
//
// Parameters
//   DEPTH        retire FIFO entries (power of two, >= 2)
//   CNT_W        width of the match, error and index counters
//   STOP_ON_FAIL 1 = halt comparison at the first mismatch, 0 = keep counting
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   check_en/pc/data/addr            retire probe input
//   exp_valid/exp_ready              expected-trace handshake
//   exp_pc/data/addr/mem/last        expected entry contents
//   match_count, err_count           saturating compare counters
//   fail, done, overflow, extra      sticky status flags
//   pass                             done & ~fail & ~overflow & ~extra
//   fail_index, fail_pc, fail_exp_pc capture of the first mismatch
// -----------------------------------------------------------------------------
module trace_checker #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned STOP_ON_FAIL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             check_en,
  input  logic [31:0]      check_pc,
  input  logic [31:0]      check_data,
  input  logic [31:0]      check_addr,
  input  logic             exp_valid,
  output logic             exp_ready,
  input  logic [31:0]      exp_pc,
  input  logic [31:0]      exp_data,
  input  logic [31:0]      exp_addr,
  input  logic             exp_mem,
  input  logic             exp_last,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] err_count,
  output logic             fail,
  output logic             done,
  output logic             pass,
  output logic             overflow,
  output logic             extra,
  output logic [CNT_W-1:0] fail_index,
  output logic [31:0]      fail_pc,
  output logic [31:0]      fail_exp_pc
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]       FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]       ZERO_CNT = {(AW+1){1'b0}};
  localparam logic [AW:0]       ONE_CNT  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0]     ONE_PTR  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HALT = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Saturating increment used by all counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  // Saturating sum giving the trace index of the entry being compared.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0]   s;
    logic [CNT_W-1:0] r;
    s = {1'b0, a} + {1'b0, b};
    if (s[CNT_W]) begin
      r = CNT_MAX;
    end else begin
      r = s[CNT_W-1:0];
    end
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [95:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [CNT_W-1:0] match_count_q, match_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] fail_index_q, fail_index_d;
  logic [31:0]      fail_pc_q, fail_pc_d;
  logic [31:0]      fail_exp_pc_q, fail_exp_pc_d;
  logic             fail_q, fail_d;
  logic             done_q, done_d;
  logic             overflow_q, overflow_d;
  logic             extra_q, extra_d;

  logic             in_run_s;
  logic             empty_s;
  logic             full_s;
  logic             pop_s;
  logic             push_s;
  logic             equal_s;
  logic [31:0]      head_pc_s;
  logic [31:0]      head_data_s;
  logic [31:0]      head_addr_s;

  // FIFO head decode and the compare/pop/push qualifiers.
  always_comb begin
    in_run_s    = (state_q == ST_RUN);
    empty_s     = (count_q == ZERO_CNT);
    full_s      = (count_q == FULL_CNT);
    head_pc_s   = mem_q[rd_ptr_q][95:64];
    head_data_s = mem_q[rd_ptr_q][63:32];
    head_addr_s = mem_q[rd_ptr_q][31:0];
    pop_s       = in_run_s && !empty_s && exp_valid;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_s      = check_en && in_run_s && (!full_s || pop_s);
    // Data and address are only meaningful for stores; non-store entries may
    // carry stale store values, so they are ignored.
    if (exp_mem) begin
      equal_s = (head_pc_s == exp_pc) && (head_data_s == exp_data) &&
                (head_addr_s == exp_addr);
    end else begin
      equal_s = (head_pc_s == exp_pc);
    end
  end

  // Next-state, counters, status flags and FIFO bookkeeping.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    match_count_d = match_count_q;
    err_count_d   = err_count_q;
    fail_index_d  = fail_index_q;
    fail_pc_d     = fail_pc_q;
    fail_exp_pc_d = fail_exp_pc_q;
    fail_d        = fail_q;
    done_d        = done_q;
    overflow_d    = overflow_q;
    extra_d       = extra_q;

    case (state_q)
      ST_RUN: begin
        if (pop_s) begin
          // The last entry always ends the run, even when it mismatched.
          if (exp_last) begin
            state_d = ST_DONE;
          end else if (!equal_s && (STOP_ON_FAIL != 0)) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: state_d = ST_HALT;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_RUN;
    endcase

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + ONE_PTR;
      if (equal_s) begin
        match_count_d = sat_inc(match_count_q);
      end else begin
        err_count_d = sat_inc(err_count_q);
        fail_d      = 1'b1;
        if (!fail_q) begin
          fail_index_d  = sat_add(match_count_q, err_count_q);
          fail_pc_d     = head_pc_s;
          fail_exp_pc_d = exp_pc;
        end else begin
          fail_index_d  = fail_index_q;
        end
      end
      if (exp_last) begin
        done_d = 1'b1;
      end else begin
        done_d = done_q;
      end
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + ONE_PTR;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase

    if (check_en && in_run_s && full_s && !pop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end

    // Retires after the trace ended, and entries left behind in the FIFO at
    // the end of the trace, are both reported as extra.
    if ((state_q == ST_DONE) && (check_en || !empty_s)) begin
      extra_d = 1'b1;
    end else begin
      extra_d = extra_q;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      wr_ptr_q      <= {AW{1'b0}};
      rd_ptr_q      <= {AW{1'b0}};
      count_q       <= ZERO_CNT;
      match_count_q <= {CNT_W{1'b0}};
      err_count_q   <= {CNT_W{1'b0}};
      fail_index_q  <= {CNT_W{1'b0}};
      fail_pc_q     <= 32'h0000_0000;
      fail_exp_pc_q <= 32'h0000_0000;
      fail_q        <= 1'b0;
      done_q        <= 1'b0;
      overflow_q    <= 1'b0;
      extra_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      match_count_q <= match_count_d;
      err_count_q   <= err_count_d;
      fail_index_q  <= fail_index_d;
      fail_pc_q     <= fail_pc_d;
      fail_exp_pc_q <= fail_exp_pc_d;
      fail_q        <= fail_d;
      done_q        <= done_d;
      overflow_q    <= overflow_d;
      extra_q       <= extra_d;
    end
  end

  // Retire FIFO storage; contents need no reset because occupancy gates reads.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {check_pc, check_data, check_addr};
    end
  end

  assign exp_ready   = pop_s;
  assign match_count = match_count_q;
  assign err_count   = err_count_q;
  assign fail        = fail_q;
  assign done        = done_q;
  assign overflow    = overflow_q;
  assign extra       = extra_q;
  assign fail_index  = fail_index_q;
  assign fail_pc     = fail_pc_q;
  assign fail_exp_pc = fail_exp_pc_q;
  assign pass        = done_q & ~fail_q & ~overflow_q & ~extra_q;

endmodule

// File: tb/tb_trace_checker.sv
// -----------------------------------------------------------------------------
// tb_trace_checker
//
// Self-checking bench for trace_checker. Instance 0 uses STOP_ON_FAIL=1 and
// instance 1 uses STOP_ON_FAIL=0; both share the same stimulus and each
// sequence checks only the instance it targets.
// -----------------------------------------------------------------------------
module tb_trace_checker;

  logic        clk;
  logic        rst;
  logic        check_en;
  logic [31:0] check_pc, check_data, check_addr;
  logic        exp_valid;
  logic [31:0] exp_pc, exp_data, exp_addr;
  logic        exp_mem, exp_last;

  logic        rdy_w   [2];
  logic [15:0] mc_w    [2];
  logic [15:0] ec_w    [2];
  logic        fail_w  [2];
  logic        done_w  [2];
  logic        pass_w  [2];
  logic        ovf_w   [2];
  logic        extra_w [2];
  logic [15:0] fidx_w  [2];
  logic [31:0] fpc_w   [2];
  logic [31:0] fepc_w  [2];

  int checks   = 0;
  int failures = 0;

  trace_checker #(.DEPTH(8), .CNT_W(16), .STOP_ON_FAIL(1)) dut_stop (
    .clk(clk), .rst(rst),
    .check_en(check_en), .check_pc(check_pc), .check_data(check_data),
    .check_addr(check_addr),
    .exp_valid(exp_valid), .exp_ready(rdy_w[0]), .exp_pc(exp_pc),
    .exp_data(exp_data), .exp_addr(exp_addr), .exp_mem(exp_mem),
    .exp_last(exp_last),
    .match_count(mc_w[0]), .err_count(ec_w[0]), .fail(fail_w[0]),
    .done(done_w[0]), .pass(pass_w[0]), .overflow(ovf_w[0]),
    .extra(extra_w[0]), .fail_index(fidx_w[0]), .fail_pc(fpc_w[0]),
    .fail_exp_pc(fepc_w[0])
  );

  trace_checker #(.DEPTH(8), .CNT_W(16), .STOP_ON_FAIL(0)) dut_cont (
    .clk(clk), .rst(rst),
    .check_en(check_en), .check_pc(check_pc), .check_data(check_data),
    .check_addr(check_addr),
    .exp_valid(exp_valid), .exp_ready(rdy_w[1]), .exp_pc(exp_pc),
    .exp_data(exp_data), .exp_addr(exp_addr), .exp_mem(exp_mem),
    .exp_last(exp_last),
    .match_count(mc_w[1]), .err_count(ec_w[1]), .fail(fail_w[1]),
    .done(done_w[1]), .pass(pass_w[1]), .overflow(ovf_w[1]),
    .extra(extra_w[1]), .fail_index(fidx_w[1]), .fail_pc(fpc_w[1]),
    .fail_exp_pc(fepc_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ce;
    logic [31:0] pc, data, addr;
    logic        ev;
    logic [31:0] epc, edata, eaddr;
    logic        emem, elast;
    logic        x_rdy;
    logic [15:0] x_mc, x_ec;
    logic        x_fail, x_done, x_pass;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, sample exp_ready, then let
  // the rising edge happen and return #1 after it.
  task automatic cyc(input logic ce, input logic [31:0] pc, input logic [31:0] data,
                     input logic [31:0] addr, input logic ev, input logic [31:0] epc,
                     input logic [31:0] edata, input logic [31:0] eaddr,
                     input logic emem, input logic elast, input int s,
                     output logic rdy);
    @(negedge clk);
    check_en = ce; check_pc = pc; check_data = data; check_addr = addr;
    exp_valid = ev; exp_pc = epc; exp_data = edata; exp_addr = eaddr;
    exp_mem = emem; exp_last = elast;
    #1;
    rdy = rdy_w[s];
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    check_en = 1'b0; check_pc = 32'h0; check_data = 32'h0; check_addr = 32'h0;
    exp_valid = 1'b0; exp_pc = 32'h0; exp_data = 32'h0; exp_addr = 32'h0;
    exp_mem = 1'b0; exp_last = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic r;
    logic [31:0] e;

    // ---------------- vector table: in-order stream of 10 ----------------
    // Row k pushes retire k and offers expected entry k-1. Entries with
    // index % 3 != 0 are non-stores whose data/address deliberately differ.
    for (int k = 0; k < 11; k++) begin
      int j;
      j = k - 1;
      tbl[k].ce    = (k < 10);
      tbl[k].pc    = 32'h0000_1000 + 32'(4 * k);
      tbl[k].data  = 32'hD000_0000 + 32'(k);
      tbl[k].addr  = 32'hA000_0000 + 32'(16 * k);
      tbl[k].ev    = 1'b1;
      tbl[k].emem  = (k >= 1) && (j % 3 == 0);
      tbl[k].epc   = (k >= 1) ? 32'h0000_1000 + 32'(4 * j) : 32'h0;
      tbl[k].edata = tbl[k].emem ? 32'hD000_0000 + 32'(j) : 32'h5555_0000 + 32'(j);
      tbl[k].eaddr = tbl[k].emem ? 32'hA000_0000 + 32'(16 * j) : 32'h7777_0000;
      tbl[k].elast = (j == 9);
      tbl[k].x_rdy  = (k >= 1);
      tbl[k].x_mc   = 16'(k);
      tbl[k].x_ec   = 16'd0;
      tbl[k].x_fail = 1'b0;
      tbl[k].x_done = (k == 10);
      tbl[k].x_pass = (k == 10);
    end

    rst = 1'b1;
    do_reset();
    #1;
    chk("reset_rdy",   32'(rdy_w[0]), 32'h0);
    chk("reset_mc",    32'(mc_w[0]),  32'h0);
    chk("reset_ec",    32'(ec_w[0]),  32'h0);
    chk("reset_flags", {28'h0, fail_w[0], done_w[0], ovf_w[0], extra_w[0]}, 32'h0);
    chk("reset_pass",  32'(pass_w[0]), 32'h0);
    chk("reset_fidx",  32'(fidx_w[0]), 32'h0);
    chk("reset_fpc",   fpc_w[0] | fepc_w[0], 32'h0);

    for (int k = 0; k < 11; k++) begin
      cyc(tbl[k].ce, tbl[k].pc, tbl[k].data, tbl[k].addr, tbl[k].ev, tbl[k].epc,
          tbl[k].edata, tbl[k].eaddr, tbl[k].emem, tbl[k].elast, 0, r);
      chk($sformatf("stream_rdy[%0d]", k),  32'(r),          32'(tbl[k].x_rdy));
      chk($sformatf("stream_mc[%0d]", k),   32'(mc_w[0]),    32'(tbl[k].x_mc));
      chk($sformatf("stream_ec[%0d]", k),   32'(ec_w[0]),    32'(tbl[k].x_ec));
      chk($sformatf("stream_fail[%0d]", k), 32'(fail_w[0]),  32'(tbl[k].x_fail));
      chk($sformatf("stream_done[%0d]", k), 32'(done_w[0]),  32'(tbl[k].x_done));
      chk($sformatf("stream_pass[%0d]", k), 32'(pass_w[0]),  32'(tbl[k].x_pass));
    end
    chk("stream_extra", 32'(extra_w[0]), 32'h0);
    // After DONE, the port no longer accepts entries.
    cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 0, r);
    chk("done_rdy_low", 32'(r), 32'h0);

    // ---------------- store mismatch with STOP_ON_FAIL=1 ----------------
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 32'h100 + 32'(4 * i), (i == 3) ? 32'h1235 : 32'h50 + 32'(i),
          32'h800 + 32'(4 * i), 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 0, r);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h100 + 32'(4 * i),
          (i == 3) ? 32'h1234 : 32'h0, 32'h800 + 32'(4 * i), (i == 3), 1'b0, 0, r);
      chk($sformatf("store_rdy[%0d]", i), 32'(r), 32'h1);
    end
    chk("store_fail",  32'(fail_w[0]), 32'h1);
    chk("store_fidx",  32'(fidx_w[0]), 32'd3);
    chk("store_mc",    32'(mc_w[0]),   32'd3);
    chk("store_ec",    32'(ec_w[0]),   32'd1);
    chk("store_fpc",   fpc_w[0],       32'h10C);
    chk("store_fepc",  fepc_w[0],      32'h10C);
    // HALT: no more compares, retires silently discarded.
    cyc(1'b1, 32'h200, 32'h0, 32'h0, 1'b1, 32'h110, 32'h0, 32'h0, 1'b0, 1'b0, 0, r);
    chk("halt_rdy",    32'(r),          32'h0);
    chk("halt_mc",     32'(mc_w[0]),    32'd3);
    chk("halt_flags",  {30'h0, ovf_w[0], extra_w[0]}, 32'h0);
    chk("halt_done",   32'(done_w[0]),  32'h0);

    // ---------------- backpressure and overflow ----------------
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, 32'h400 + 32'(4 * i), 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0,
          1'b0, 1'b0, 0, r);
      if (i == 7) chk("ovf_after8", 32'(ovf_w[0]), 32'h0);
    end
    chk("ovf_after9", 32'(ovf_w[0]), 32'h1);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h400 + 32'(4 * i), 32'h0, 32'h0,
          1'b0, 1'b0, 0, r);
      chk($sformatf("drain_rdy[%0d]", i), 32'(r), 32'h1);
    end
    chk("drain_mc", 32'(mc_w[0]), 32'd8);
    chk("drain_ec", 32'(ec_w[0]), 32'd0);
    cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h420, 32'h0, 32'h0, 1'b0, 1'b0, 0, r);
    chk("drain_empty_rdy", 32'(r), 32'h0);

    // ---------------- push and pop while full ----------------
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 32'h500 + 32'(4 * i), 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0,
          1'b0, 1'b0, 0, r);
    end
    cyc(1'b1, 32'h520, 32'h0, 32'h0, 1'b1, 32'h500, 32'h0, 32'h0, 1'b0, 1'b0, 0, r);
    chk("full_pp_rdy", 32'(r),        32'h1);
    chk("full_pp_ovf", 32'(ovf_w[0]), 32'h0);
    chk("full_pp_mc",  32'(mc_w[0]),  32'd1);
    // Still full: one more retire without a pop must be dropped.
    cyc(1'b1, 32'h524, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 0, r);
    chk("full_still_ovf", 32'(ovf_w[0]), 32'h1);
    // Remaining entries are 0x504..0x520 in order.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h504 + 32'(4 * i), 32'h0, 32'h0,
          1'b0, 1'b0, 0, r);
    end
    chk("full_drain_mc", 32'(mc_w[0]), 32'd9);
    chk("full_drain_ec", 32'(ec_w[0]), 32'd0);

    // ---------------- continue mode (STOP_ON_FAIL=0) ----------------
    do_reset();
    for (int k = 0; k < 9; k++) begin
      int j;
      j = k - 1;
      e = 32'h300 + 32'(4 * j);
      if (j == 2 || j == 5) e = e ^ 32'h1;
      cyc((k < 8), 32'h300 + 32'(4 * k), 32'h0, 32'h0, (k >= 1), e, 32'h0, 32'h0,
          1'b0, (j == 7), 1, r);
      if (k >= 1) chk($sformatf("cont_rdy[%0d]", k), 32'(r), 32'h1);
      if (k == 3) chk("cont_fail_at2", {ec_w[1], 15'h0, fail_w[1]}, {16'd1, 16'd1});
    end
    chk("cont_mc",    32'(mc_w[1]),    32'd6);
    chk("cont_ec",    32'(ec_w[1]),    32'd2);
    chk("cont_fidx",  32'(fidx_w[1]),  32'd2);
    chk("cont_fpc",   fpc_w[1],        32'h308);
    chk("cont_fepc",  fepc_w[1],       32'h309);
    chk("cont_done",  32'(done_w[1]),  32'h1);
    chk("cont_pass",  32'(pass_w[1]),  32'h0);
    chk("cont_extra0", 32'(extra_w[1]), 32'h0);
    cyc(1'b1, 32'h400, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1, r);
    chk("cont_extra1", 32'(extra_w[1]), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
